// File: rtl/dca_matrix_row_streamer.sv
// Row-level load/store sequencer for the move port of one DCA matrix register.
// Optional macro DCA_MATRIX_ROW_STREAMER_RESTORE_EN makes stores non-destructive by rotating the matrix.
module dca_matrix_row_streamer #(
  parameter int MATRIX_NUM_ROW   = 8,
  parameter int MATRIX_NUM_COL   = 8,
  parameter int BW_TENSOR_SCALAR = 32,
  parameter int BW_ROW           = MATRIX_NUM_COL * BW_TENSOR_SCALAR,
  parameter int BW_NUM_ROW       = $clog2(MATRIX_NUM_ROW + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_store,
  input  logic [BW_NUM_ROW-1:0] cmd_num_row,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [BW_ROW-1:0]     s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [BW_ROW-1:0]     m_data,
  output logic                  mreg_move_wenable,
  output logic [BW_ROW-1:0]     mreg_move_wdata_list,
  output logic                  mreg_move_renable,
  input  logic [BW_ROW-1:0]     mreg_move_rdata_list,
  output logic                  busy,
  output logic                  done
);

  localparam logic [BW_NUM_ROW-1:0] NUM_MAX = BW_NUM_ROW'(MATRIX_NUM_ROW);
  localparam logic [BW_NUM_ROW-1:0] ONE     = BW_NUM_ROW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PAD   = 3'd2,
    STORE = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t                state, state_next;
  logic [BW_NUM_ROW-1:0] num;
  logic [BW_NUM_ROW-1:0] row_cnt, row_cnt_next;
  logic [BW_NUM_ROW-1:0] cnt_inc;
  logic [BW_NUM_ROW-1:0] num_clamped;
  logic                  accept;
  logic                  rd_fire;
  logic                  done_next;

`ifdef DCA_MATRIX_ROW_STREAMER_RESTORE_EN
  logic                  is_store;
`endif

  assign accept      = (state == IDLE) && cmd_valid;
  assign cnt_inc     = row_cnt + ONE;
  assign num_clamped = ((cmd_num_row == '0) || (cmd_num_row > NUM_MAX)) ? NUM_MAX : cmd_num_row;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      num     <= '0;
      row_cnt <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      row_cnt <= row_cnt_next;
      done    <= done_next;
      if (accept) begin
        num <= num_clamped;
      end
      // Output register: a read refills it, an accepted beat with no refill empties it.
      if (rd_fire) begin
        m_data  <= mreg_move_rdata_list;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef DCA_MATRIX_ROW_STREAMER_RESTORE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      is_store <= 1'b0;
    end else if (accept) begin
      is_store <= cmd_store;
    end
  end
`endif

  always_comb begin
    state_next           = state;
    row_cnt_next         = row_cnt;
    done_next            = 1'b0;
    cmd_ready            = 1'b0;
    s_ready              = 1'b0;
    rd_fire              = 1'b0;
    mreg_move_wenable    = 1'b0;
    mreg_move_wdata_list = '0;
    mreg_move_renable    = 1'b0;

    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          row_cnt_next = '0;
          state_next   = cmd_store ? STORE : LOAD;
        end
      end

      LOAD: begin
        s_ready              = 1'b1;
        mreg_move_wenable    = s_valid;
        mreg_move_wdata_list = s_data;
        if (s_valid) begin
          row_cnt_next = cnt_inc;
          if (cnt_inc == num) begin
            if (num < NUM_MAX) begin
              state_next = PAD;
            end else begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end
        end
      end

      // Pushes the loaded rows up until the first one reaches the top row.
      PAD: begin
        mreg_move_wenable = 1'b1;
`ifdef DCA_MATRIX_ROW_STREAMER_RESTORE_EN
        mreg_move_wdata_list = is_store ? mreg_move_rdata_list : '0;
`endif
        row_cnt_next = cnt_inc;
        if (cnt_inc >= NUM_MAX) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end

      STORE: begin
        rd_fire = (row_cnt < num) && (!m_valid || m_ready);
`ifdef DCA_MATRIX_ROW_STREAMER_RESTORE_EN
        mreg_move_wenable    = rd_fire;
        mreg_move_wdata_list = rd_fire ? mreg_move_rdata_list : '0;
`else
        mreg_move_renable    = rd_fire;
`endif
        if (rd_fire) begin
          row_cnt_next = cnt_inc;
          if (cnt_inc == num) begin
            state_next = DRAIN;
          end
        end else if (row_cnt >= num) begin
          state_next = DRAIN;
        end
      end

      DRAIN: begin
        if (!m_valid || m_ready) begin
`ifdef DCA_MATRIX_ROW_STREAMER_RESTORE_EN
          if (num < NUM_MAX) begin
            state_next = PAD;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
`else
          state_next = IDLE;
          done_next  = 1'b1;
`endif
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
